// File: rtl/img_rd_tx.sv
`timescale 1ns/1ps
// img_rd_tx: image read-back transmitter.
// On start, reads words 0..DATA_COUNT_LIMIT-1 from the image RAM and sends
// each one as two bytes (high byte first) over the UART TX byte handshake.
//
// Ports:
//   Clk, Reset             clock, asynchronous active-high reset
//   start                  one-cycle request to begin a dump (IDLE/DONE only)
//   ram_rden, ram_rdaddr   RAM read request and address
//   ram_rddata             RAM read data, valid RD_LATENCY cycles after ram_rden
//   tx_data, send_en       byte and one-cycle send request to the UART TX
//   tx_done                one-cycle byte-finished pulse from the UART TX
//   busy                   high while a dump is in progress
//   read_done              sticky, set after the final byte's tx_done
module img_rd_tx #(
  parameter logic [15:0] DATA_COUNT_LIMIT = 16'hFFFF,
  parameter int unsigned RD_LATENCY       = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  output logic        ram_rden,
  output logic [15:0] ram_rdaddr,
  input  logic [15:0] ram_rddata,
  output logic [7:0]  tx_data,
  output logic        send_en,
  input  logic        tx_done,
  output logic        busy,
  output logic        read_done
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LAT_W  = 2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DATA_COUNT_LIMIT - 16'd1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_SEND_HI,
    S_WAIT_HI,
    S_SEND_LO,
    S_WAIT_LO,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0] addr;
  logic [BYTE_W-1:0] lo_byte;
  logic [LAT_W-1:0]  lat_cnt;

  logic              start_ok_c;
  logic              rd_cap_c;
  logic              last_word_c;

  logic              ram_rden_d;
  logic              send_en_d;
  logic              busy_d;
  logic              read_done_d;
  logic [BYTE_W-1:0] tx_data_d;

  assign start_ok_c  = start && ((state == S_IDLE) || (state == S_DONE));
  assign rd_cap_c    = (state == S_RD_WAIT) && (lat_cnt == LAT_LAST);
  assign last_word_c = (addr == LAST_ADDR);

  // The address counter drives the RAM address directly; it only moves on
  // the way into RD_REQ, so it holds between reads.
  assign ram_rdaddr = addr;

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start)    state_nxt = S_RD_REQ;
      S_RD_REQ:                     state_nxt = S_RD_WAIT;
      S_RD_WAIT:      if (rd_cap_c) state_nxt = S_SEND_HI;
      S_SEND_HI:                    state_nxt = S_WAIT_HI;
      S_WAIT_HI:      if (tx_done)  state_nxt = S_SEND_LO;
      S_SEND_LO:                    state_nxt = S_WAIT_LO;
      S_WAIT_LO: begin
        if (tx_done) state_nxt = last_word_c ? S_DONE : S_RD_REQ;
      end
      default:                      state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, decoded from the
  // upcoming state so each output lines up with its state's cycle.
  always_comb begin
    ram_rden_d  = (state_nxt == S_RD_REQ);
    send_en_d   = (state_nxt == S_SEND_HI) || (state_nxt == S_SEND_LO);
    busy_d      = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
    read_done_d = (state_nxt == S_DONE);
    tx_data_d   = tx_data;
    // SEND_HI is only entered on the capture edge, so the high byte comes
    // straight from the RAM data being captured.
    if (state_nxt == S_SEND_HI) begin
      tx_data_d = ram_rddata[15:8];
    end else if (state_nxt == S_SEND_LO) begin
      tx_data_d = lo_byte;
    end
  end

  // Registered outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ram_rden  <= 1'b0;
      send_en   <= 1'b0;
      busy      <= 1'b0;
      read_done <= 1'b0;
      tx_data   <= '0;
    end else begin
      ram_rden  <= ram_rden_d;
      send_en   <= send_en_d;
      busy      <= busy_d;
      read_done <= read_done_d;
      tx_data   <= tx_data_d;
    end
  end

  // Address counter, captured low byte and read-latency counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr    <= '0;
      lo_byte <= '0;
      lat_cnt <= '0;
    end else begin
      if (start_ok_c) begin
        addr <= '0;
      end else if ((state == S_WAIT_LO) && tx_done && !last_word_c) begin
        addr <= addr + ADDR_W'(1);
      end

      if (rd_cap_c) begin
        lo_byte <= ram_rddata[7:0];
      end

      if (state == S_RD_REQ) begin
        lat_cnt <= '0;
      end else if (state == S_RD_WAIT) begin
        lat_cnt <= lat_cnt + LAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_img_rd_tx.sv
`timescale 1ns/1ps
// Bench for img_rd_tx: two instances (read latency 1 and 2, four words),
// each with a RAM model and a UART TX model, checked against the expected
// byte stream and handshake timing derived from the RAM contents.
module tb_img_rd_tx;

  localparam int unsigned N_WORDS = 4;
  localparam int unsigned LOG_SZ  = 32768;
  localparam int          BUDGET  = 2000;

  logic        Clk;
  logic        Reset;
  logic [1:0]  start;
  logic [1:0]  spur;
  logic [1:0]  txd_m;
  logic [1:0]  ram_rden;
  logic [1:0]  send_en;
  logic [1:0]  busy;
  logic [1:0]  read_done;
  logic [15:0] ram_rdaddr [2];
  logic [15:0] ram_rddata [2];
  logic [7:0]  tx_data    [2];

  int          tx_delay [2];
  logic [15:0] mem [2][N_WORDS];

  // model / monitor state (written only by the negedge block)
  int          tx_cnt  [2];
  int          rd_pend [2];
  logic [1:0]  rd_addr [2];
  bit          pending [2];
  logic [7:0]  held    [2];
  bit          rd_prev [2];
  int          sent_n [2];
  int          rd_n   [2];
  int          done_n [2];
  int          unstable [2];
  int          rise_c [2];
  logic [7:0]  sent_b [2][LOG_SZ];
  int          sent_c [2][LOG_SZ];
  logic [15:0] rd_a   [2][LOG_SZ];
  int          rd_c   [2][LOG_SZ];
  int          done_c [2][LOG_SZ];

  int cyc;
  int n_cmp;
  int n_err;

  img_rd_tx #(.DATA_COUNT_LIMIT(16'd4), .RD_LATENCY(1)) u_dut_l1 (
    .Clk(Clk), .Reset(Reset), .start(start[0]),
    .ram_rden(ram_rden[0]), .ram_rdaddr(ram_rdaddr[0]), .ram_rddata(ram_rddata[0]),
    .tx_data(tx_data[0]), .send_en(send_en[0]), .tx_done(txd_m[0] | spur[0]),
    .busy(busy[0]), .read_done(read_done[0])
  );

  img_rd_tx #(.DATA_COUNT_LIMIT(16'd4), .RD_LATENCY(2)) u_dut_l2 (
    .Clk(Clk), .Reset(Reset), .start(start[1]),
    .ram_rden(ram_rden[1]), .ram_rdaddr(ram_rdaddr[1]), .ram_rddata(ram_rddata[1]),
    .tx_data(tx_data[1]), .send_en(send_en[1]), .tx_done(txd_m[1] | spur[1]),
    .busy(busy[1]), .read_done(read_done[1])
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  // RAM + TX models and event logging; everything sampled mid-cycle.
  always @(negedge Clk) begin
    for (int g = 0; g < 2; g++) begin
      txd_m[g]      = 1'b0;
      ram_rddata[g] = 16'($urandom);
      if (Reset) begin
        tx_cnt[g]  = 0;
        rd_pend[g] = 0;
        pending[g] = 1'b0;
      end else begin
        if (tx_cnt[g] > 0) begin
          tx_cnt[g]--;
          if (tx_cnt[g] == 0) txd_m[g] = 1'b1;
        end
        if (send_en[g]) tx_cnt[g] = tx_delay[g];
        if (rd_pend[g] > 0) begin
          rd_pend[g]--;
          if (rd_pend[g] == 0) ram_rddata[g] = mem[g][rd_addr[g]];
        end
        if (ram_rden[g]) begin
          rd_pend[g] = g + 1;
          rd_addr[g] = ram_rdaddr[g][1:0];
        end
      end

      if (send_en[g]) begin
        if (sent_n[g] < LOG_SZ) begin
          sent_b[g][sent_n[g]] = tx_data[g];
          sent_c[g][sent_n[g]] = cyc;
        end
        sent_n[g]++;
        held[g]    = tx_data[g];
        pending[g] = !Reset;
      end else if (pending[g]) begin
        if (tx_data[g] != held[g]) unstable[g]++;
        if (txd_m[g]) pending[g] = 1'b0;
      end
      if (txd_m[g]) begin
        if (done_n[g] < LOG_SZ) done_c[g][done_n[g]] = cyc;
        done_n[g]++;
      end
      if (ram_rden[g]) begin
        if (rd_n[g] < LOG_SZ) begin
          rd_a[g][rd_n[g]] = ram_rdaddr[g];
          rd_c[g][rd_n[g]] = cyc;
        end
        rd_n[g]++;
      end
      if (read_done[g] && !rd_prev[g]) rise_c[g] = cyc;
      rd_prev[g] = read_done[g];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input int d, input string where);
    check($sformatf("%s d%0d busy", where, d), 32'(busy[d]), 32'd0);
    check($sformatf("%s d%0d read_done", where, d), 32'(read_done[d]), 32'd0);
    check($sformatf("%s d%0d send_en", where, d), 32'(send_en[d]), 32'd0);
    check($sformatf("%s d%0d ram_rden", where, d), 32'(ram_rden[d]), 32'd0);
    check($sformatf("%s d%0d ram_rdaddr", where, d), 32'(ram_rdaddr[d]), 32'd0);
    check($sformatf("%s d%0d tx_data", where, d), 32'(tx_data[d]), 32'd0);
  endtask

  task automatic load_fixed(input int d);
    mem[d][0] = 16'h1234;
    mem[d][1] = 16'hABCD;
    mem[d][2] = 16'h00FF;
    mem[d][3] = 16'h8001;
  endtask

  // One full dump on instance d; noisy adds start pulses while busy and
  // spurious tx_done in RD_WAIT and in the send_en cycle.
  task automatic run_dump(input int d, input int delay, input bit noisy);
    int ks, bs, br, bd, bu, lat, bad, min_gap, gap;
    bit ok, seen_rd;
    logic [7:0] exp_b [2*N_WORDS];
    string t;
    t   = $sformatf("d%0d dly%0d", d, delay);
    lat = d + 1;
    tx_delay[d] = delay;
    for (int w = 0; w < N_WORDS; w++) begin
      exp_b[2*w]   = mem[d][w][15:8];
      exp_b[2*w+1] = mem[d][w][7:0];
    end
    bs = sent_n[d]; br = rd_n[d]; bd = done_n[d]; bu = unstable[d];

    start[d] = 1'b1;
    ks = cyc;
    @(negedge Clk);
    start[d] = 1'b0;
    check({t, " busy_after_start"}, 32'(busy[d]), 32'd1);
    check({t, " read_done_cleared"}, 32'(read_done[d]), 32'd0);
    check({t, " first_rdaddr"}, 32'(ram_rdaddr[d]), 32'd0);

    ok = 1'b0;
    seen_rd = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      start[d] = 1'b0;
      spur[d]  = 1'b0;
      if (read_done[d]) begin
        ok = 1'b1;
        break;
      end
      if (noisy) begin
        spur[d]  = seen_rd || send_en[d];
        start[d] = !spur[d] && busy[d] && ($urandom_range(0, 2) == 0);
        seen_rd  = ram_rden[d];
      end
      @(negedge Clk);
    end
    start[d] = 1'b0;
    spur[d]  = 1'b0;
    check({t, " done_in_budget"}, 32'(ok), 32'd1);
    @(negedge Clk);
    check({t, " busy_at_end"}, 32'(busy[d]), 32'd0);
    check({t, " read_done_at_end"}, 32'(read_done[d]), 32'd1);

    check({t, " send_count"}, 32'(sent_n[d] - bs), 32'(2 * N_WORDS));
    for (int i = 0; i < 2 * N_WORDS; i++)
      check($sformatf("%s byte%0d", t, i), 32'(sent_b[d][bs+i]), 32'(exp_b[i]));
    check({t, " rden_count"}, 32'(rd_n[d] - br), 32'(N_WORDS));
    for (int w = 0; w < N_WORDS; w++)
      check($sformatf("%s rden_addr%0d", t, w), 32'(rd_a[d][br+w]), 32'(w));
    check({t, " done_count"}, 32'(done_n[d] - bd), 32'(2 * N_WORDS));
    check({t, " first_rden_cyc"}, 32'(rd_c[d][br]), 32'(ks + 1));
    check({t, " first_send_cyc"}, 32'(sent_c[d][bs]), 32'(ks + 2 + lat));

    bad = 0;
    for (int w = 0; w < N_WORDS; w++) begin
      if (sent_c[d][bs+2*w] != rd_c[d][br+w] + 1 + lat) bad++;
      if (sent_c[d][bs+2*w+1] != done_c[d][bd+2*w] + 1) bad++;
      if (w < N_WORDS - 1 && rd_c[d][br+w+1] != done_c[d][bd+2*w+1] + 1) bad++;
    end
    check({t, " handshake_timing_errors"}, 32'(bad), 32'd0);
    check({t, " read_done_rise_cyc"}, 32'(rise_c[d]), 32'(done_c[d][bd+2*N_WORDS-1] + 1));

    min_gap = 1000000;
    for (int i = 1; i < 2 * N_WORDS; i++) begin
      gap = sent_c[d][bs+i] - sent_c[d][bs+i-1];
      if (gap < min_gap) min_gap = gap;
    end
    check({t, " send_gap_ge2"}, 32'(min_gap >= 2), 32'd1);
    check({t, " tx_data_unstable"}, 32'(unstable[d] - bu), 32'd0);
  endtask

  initial begin
    int bs, c, d, dly;
    bit nz;
    Reset = 1'b1;
    start = '0;
    spur  = '0;
    tx_delay[0] = 10;
    tx_delay[1] = 10;
    load_fixed(0);
    load_fixed(1);
    repeat (3) @(negedge Clk);
    check_idle_outputs(0, "reset");
    check_idle_outputs(1, "reset");
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // fixed image, both latencies, then a repeat dump from DONE
    run_dump(0, 10, 1'b0);
    repeat (20) @(negedge Clk);
    check("d0 read_done_sticky", 32'(read_done[0]), 32'd1);
    check("d0 busy_idle_after_done", 32'(busy[0]), 32'd0);
    run_dump(0, 10, 1'b0);
    run_dump(1, 10, 1'b0);

    // start while busy plus spurious tx_done
    run_dump(0, 4, 1'b1);
    run_dump(1, 5, 1'b1);

    // fastest TX
    run_dump(0, 1, 1'b0);
    run_dump(1, 1, 1'b0);

    // reset during WAIT_LO of word 1
    tx_delay[0] = 10;
    bs = sent_n[0];
    start[0] = 1'b1;
    @(negedge Clk);
    start[0] = 1'b0;
    c = 0;
    while (sent_n[0] < bs + 4 && c < 500) begin
      @(negedge Clk);
      c++;
    end
    check("rst_mid reached_word1_lo", 32'(sent_n[0] >= bs + 4), 32'd1);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    #1;
    check_idle_outputs(0, "rst_mid");
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    bs = sent_n[0];
    repeat (20) @(negedge Clk);
    check("rst_mid no_send_after_reset", 32'(sent_n[0] - bs), 32'd0);
    check("rst_mid busy_after_reset", 32'(busy[0]), 32'd0);
    run_dump(0, 10, 1'b0);

    // random images, TX delays and noise
    for (int it = 0; it < 8; it++) begin
      d   = int'($urandom_range(0, 1));
      dly = int'($urandom_range(1, 12));
      nz  = 1'($urandom_range(0, 1));
      for (int w = 0; w < N_WORDS; w++) mem[d][w] = 16'($urandom);
      run_dump(d, dly, nz);
      repeat (int'($urandom_range(0, 5))) @(negedge Clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/img_rd_tx.md
Name: img_rd_tx

Overview:
Image read-back transmitter. On a start pulse it reads 16-bit words sequentially from the image RAM and sends each word as two bytes, high byte first, through the UART transmitter's byte handshake. It is the mirror of the UART-to-RAM image write path: the byte order and word addressing are identical, so a dumped image round-trips bit-exact. It sits between the image RAM's read port and the UART TX byte interface.

Parameters:
DATA_COUNT_LIMIT, 16'hFFFF, number of words sent per dump (addresses 0 .. DATA_COUNT_LIMIT-1); must be >= 1.
RD_LATENCY, 1, RAM read latency in clocks from ram_rden to valid ram_rddata; legal values are 1 and 2.

Ports:
Clk  input  1  system clock; all logic on the rising edge.
Reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request to begin a dump.
ram_rden  output  1  RAM read enable, one-cycle pulse per word.
ram_rdaddr  output  16  RAM read address.
ram_rddata  input  16  RAM read data, valid RD_LATENCY cycles after ram_rden.
tx_data  output  8  byte to the UART transmitter.
send_en  output  1  one-cycle pulse requesting transmission of tx_data.
tx_done  input  1  one-cycle pulse from the UART transmitter when the byte has finished.
busy  output  1  high while a dump is in progress.
read_done  output  1  sticky flag, high after the last byte's tx_done.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; all outputs 0; internal address counter, word register and latency counter 0. Reset mid-dump aborts the dump immediately and sends no further send_en.
- States: IDLE, RD_REQ, RD_WAIT, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, DONE.
- IDLE / DONE: start=1 moves to RD_REQ, clears read_done and the address counter, and sets busy=1 on the next cycle.
- start is ignored in every other state.
- RD_REQ: ram_rden=1 and ram_rdaddr=address for exactly one cycle, then RD_WAIT.
- RD_WAIT: counts RD_LATENCY cycles after the ram_rden cycle and captures ram_rddata into the word register on the edge ending the RD_LATENCY-th cycle, then SEND_HI.
- SEND_HI: send_en=1 for one cycle with tx_data=word[15:8], then WAIT_HI.
- WAIT_HI: waits for tx_done, then SEND_LO.
- SEND_LO: send_en=1 for one cycle with tx_data=word[7:0], then WAIT_LO.
- WAIT_LO, on tx_done:
  - if address == DATA_COUNT_LIMIT-1, go to DONE, set read_done=1 and busy=0;
  - otherwise increment the address and go to RD_REQ.
- tx_data is held stable from its send_en cycle until the matching tx_done; it is not changed outside the SEND states.
- tx_done arriving in any state other than WAIT_HI or WAIT_LO is ignored. A tx_done in the same cycle as send_en does not count; the wait begins the cycle after send_en.
- Latency: with start sampled at edge 0, ram_rden is high in cycle 1 and the first send_en is high in cycle 2+RD_LATENCY. From the final tx_done to the next word's ram_rden is exactly 1 cycle.
- ram_rdaddr holds its last value between reads; it is 0 after reset.
- The address counter is 16 bits and does not wrap within a dump (it ends at DATA_COUNT_LIMIT-1 <= 16'hFFFE).
- Whole-dump byte count = 2*DATA_COUNT_LIMIT; exactly one send_en per byte.

Test Plan:
- DATA_COUNT_LIMIT=4, RD_LATENCY=1, RAM preloaded 0..3 = 16'h1234, 16'hABCD, 16'h00FF, 16'h8001; TX model returns tx_done 10 cycles after send_en -> bytes 12,34,AB,CD,00,FF,80,01 in order, 8 send_en pulses, read_done=1 and busy=0 one cycle after the 8th tx_done.
- Same setup with RD_LATENCY=2 -> same byte stream; first send_en 4 cycles after start (2 cycles later than ram_rden + 1); ram_rden pulses at addresses 0,1,2,3.
- start pulsed again while busy, plus a spurious tx_done in SEND_HI or RD_WAIT -> no restart; byte stream unchanged; no extra send_en.
- Reset asserted while in WAIT_LO of word 1 -> all outputs 0 immediately; a new start then dumps from address 0 with the first byte 12.
- After read_done, pulse start -> read_done clears on the next cycle and the full 8-byte dump repeats identically.
- tx_done returned 1 cycle after send_en (fastest TX) -> tx_data is stable through every handshake, and each send_en is separated by at least 2 cycles.
